gfx_stream_arb: RTL and testbench
=================================

# gfx_stream_arb

Shares a single graphics pixel sink (`m_gfx_*`, normally the framebuffer writer) between `NUM_REQ` pixel producers such as shape and line drawers. A producer requests ownership with `s_req`. The arbiter picks one owner round-robin, holds the grant until that owner releases the request, and forwards the owner's pixel stream through one registered valid/ready stage. It sits between the shape sequencers and the framebuffer port.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `H_WIDTH`, default 12: x coordinate width.
- `V_WIDTH`, default 12: y coordinate width.
- `PIXEL_WIDTH`, default 12: pixel/colour width.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `s_req`  in  `NUM_REQ`: per-requester ownership request, level.
- `s_gnt`  out  `NUM_REQ`: one-hot-or-zero grant, registered.
- `s_gfx_valid`  in  `NUM_REQ`: per-requester pixel valid.
- `s_gfx_x`  in  `NUM_REQ*H_WIDTH`: packed x, requester i at `[i*H_WIDTH +: H_WIDTH]`.
- `s_gfx_y`  in  `NUM_REQ*V_WIDTH`: packed y.
- `s_gfx_pixel`  in  `NUM_REQ*PIXEL_WIDTH`: packed pixel.
- `s_gfx_ready`  out  `NUM_REQ`: per-requester ready; zero for non-owners.
- `m_gfx_valid`  out  1: output pixel valid.
- `m_gfx_x`  out  `H_WIDTH`: output x.
- `m_gfx_y`  out  `V_WIDTH`: output y.
- `m_gfx_pixel`  out  `PIXEL_WIDTH`: output pixel.
- `m_gfx_ready`  in  1: sink ready.
- `h_visible`  in  `H_WIDTH`: screen width. Used only with the clip feature.
- `v_visible`  in  `V_WIDTH`: screen height. Used only with the clip feature.

## Operation
- FSM states `IDLE` and `OWNED`.
- **Reset values:** `IDLE`; `s_gnt=0`; `m_gfx_valid=0`; `m_gfx_x`, `m_gfx_y`, `m_gfx_pixel` all 0; round-robin pointer `ptr=0`.
- **`IDLE`:**
  - If `s_req != 0`, pick the first set bit searching upward from `ptr` with wrap.
  - Register `owner` and `s_gnt[owner]=1`, then go to `OWNED`.
  - If no request, stay in `IDLE`.
- **`OWNED`:**
  - Forward `s_gfx_*[owner]` into the output stage.
  - `s_gfx_ready[owner] = !m_gfx_valid || m_gfx_ready`. Full throughput, no bubbles.
  - When `s_req[owner]` is sampled low: clear `s_gnt`, set `ptr = owner+1` (mod `NUM_REQ`), go to `IDLE`.
- **Release rule:** `s_req` may drop only when the requester has no unaccepted beat pending.
  - Valid from a non-owner is ignored. It is never forwarded and its ready stays 0.
- **Output stage after release:** a beat already in the output register stays valid until `m_gfx_ready`. A new owner's beats queue behind it through the same ready rule, so order is preserved.
- **Request dropped before grant:** if a requester drops `s_req` before it is granted, nothing happens for it.
- **Reset mid-transfer:** asynchronously clears any pending output beat. A half-delivered job is lost; the producer restarts it.
- **Single requester:** regains the grant every second cycle of repeated requests.

## Timing
- Grant latency: `s_req` rises in cycle N, `s_gnt` is high in N+1, first beat is accepted at the earliest in N+1.
- Data latency: a beat accepted in cycle N is presented on `m_gfx_*` in N+1.
- Release: `s_req` low sampled at N → `s_gnt` low in N+1 and `IDLE` in N+1. The next grant is at N+2.
- Simultaneous requests: the round-robin pointer decides. After owner k releases, requester k has the lowest priority.
- Output register under backpressure: `m_gfx_*` is held stable while `m_gfx_valid && !m_gfx_ready`.

## Configuration
- `GFX_STREAM_ARB_CLIP_EN` defined:
  - An owner beat with `x >= h_visible` or `y >= v_visible` is accepted under the normal ready rule but is not loaded into the output stage.
  - It is silently dropped, with no bubble charged to the sink.
- `GFX_STREAM_ARB_CLIP_EN` undefined: every beat is forwarded. `h_visible` and `v_visible` are unused.

## Structure
- Shared package `gfx_pkg`: the `gfx_arb_state_t` enum (`IDLE`, `OWNED`) and the max-requester constant `GFX_ARB_MAX_REQ = 8`.
- Sub-module `gfx_rr_pick`: combinational round-robin picker.
  - Inputs: `req[NUM_REQ]`, `ptr`.
  - Outputs: `valid`, `idx`.
- Kept separate so the framebuffer read arbiter can reuse it.

## Test plan
- **Single owner:** req0 high, 4 beats (10,20,0xF00)…(13,20,0xF00), sink always ready → `s_gnt=01` at cycle 1; outputs appear 1 cycle after each acceptance, in order; `m_gfx_valid` is contiguous.
- **Contention:** req0 and req1 rise together after reset → grant 0 first. After req0 drops → `s_gnt=00` for one cycle, then `10`. Next simultaneous round → grant 0 again, because the pointer advanced past 1.
- **Backpressure:** `m_gfx_ready` low 3 cycles mid-stream → `m_gfx_*` frozen and owner ready low. No beat lost or duplicated; all 8 beats are received.
- **Non-owner noise:** req1 valid held high while 0 owns → `s_gfx_ready[1]=0`; none of req1's beats appear on the output.
- **Reset mid-transfer:** assert `rst` while `m_gfx_valid=1` → `m_gfx_valid=0` and `s_gnt=0` immediately, without waiting for a clock edge; `IDLE` after reset.
- **Clip** (macro on, `h_visible=640`, `v_visible=480`): beats (639,479), (640,0), (0,480) → only (639,479) is output; all three are accepted.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics-stream types: arbiter FSM state encoding and requester limit.
package gfx_pkg;

   localparam int GFX_ARB_MAX_REQ = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } gfx_arb_state_t;

endpackage

// File: rtl/gfx_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr, with wrap.
module gfx_rr_pick
   import gfx_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(NUM_REQ);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest set bit wins last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      sum   = '0;
      cand  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sum = {1'b0, ptr} + {1'b0, IDX_W'(i)};
         if (sum >= N_W) sum = sum - N_W;
         cand = sum[IDX_W-1:0];
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/gfx_stream_arb.sv
// Round-robin owner arbiter sharing one registered pixel sink between NUM_REQ producers.
// Optional clipping of off-screen beats when GFX_STREAM_ARB_CLIP_EN is defined.
module gfx_stream_arb
   import gfx_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int H_WIDTH     = 12,
   parameter int V_WIDTH     = 12,
   parameter int PIXEL_WIDTH = 12
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             s_req,
   output logic [NUM_REQ-1:0]             s_gnt,
   input  logic [NUM_REQ-1:0]             s_gfx_valid,
   input  logic [NUM_REQ*H_WIDTH-1:0]     s_gfx_x,
   input  logic [NUM_REQ*V_WIDTH-1:0]     s_gfx_y,
   input  logic [NUM_REQ*PIXEL_WIDTH-1:0] s_gfx_pixel,
   output logic [NUM_REQ-1:0]             s_gfx_ready,
   output logic                           m_gfx_valid,
   output logic [H_WIDTH-1:0]             m_gfx_x,
   output logic [V_WIDTH-1:0]             m_gfx_y,
   output logic [PIXEL_WIDTH-1:0]         m_gfx_pixel,
   input  logic                           m_gfx_ready,
   input  logic [H_WIDTH-1:0]             h_visible,
   input  logic [V_WIDTH-1:0]             v_visible
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   gfx_arb_state_t   state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] ptr;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;

   logic [H_WIDTH-1:0]     own_x;
   logic [V_WIDTH-1:0]     own_y;
   logic [PIXEL_WIDTH-1:0] own_pixel;
   logic                   take;
   logic                   accept;
   logic                   in_vis;

   gfx_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .req   (s_req),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign own_x     = s_gfx_x[owner*H_WIDTH +: H_WIDTH];
   assign own_y     = s_gfx_y[owner*V_WIDTH +: V_WIDTH];
   assign own_pixel = s_gfx_pixel[owner*PIXEL_WIDTH +: PIXEL_WIDTH];

`ifdef GFX_STREAM_ARB_CLIP_EN
   assign in_vis = (own_x < h_visible) && (own_y < v_visible);
`else
   wire unused_vis = ^{h_visible, v_visible};
   assign in_vis = 1'b1;
`endif

   // Handshake: a beat moves when valid && ready in the same cycle; valid never
   // waits on ready, and the output register may refill in the cycle it drains.
   assign take   = !m_gfx_valid || m_gfx_ready;
   assign accept = (state == OWNED) && s_gfx_valid[owner] && take;

   always_comb begin
      s_gfx_ready = '0;
      if (state == OWNED) s_gfx_ready[owner] = take;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         owner <= '0;
         ptr   <= '0;
         s_gnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  owner <= pick_idx;
                  s_gnt <= NUM_REQ'(1) << pick_idx;
                  state <= OWNED;
               end
            end
            default: begin
               if (!s_req[owner]) begin
                  s_gnt <= '0;
                  ptr   <= (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   // Clipped beats are consumed from the producer but never occupy the register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_gfx_valid <= 1'b0;
         m_gfx_x     <= '0;
         m_gfx_y     <= '0;
         m_gfx_pixel <= '0;
      end else if (accept && in_vis) begin
         m_gfx_valid <= 1'b1;
         m_gfx_x     <= own_x;
         m_gfx_y     <= own_y;
         m_gfx_pixel <= own_pixel;
      end else if (m_gfx_ready) begin
         m_gfx_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gfx_stream_arb.sv
// Bench for gfx_stream_arb: grant table, streamed beats through a scoreboard, corner sequences.
module tb_gfx_stream_arb;

   logic        clk;
   logic        rst;
   logic [1:0]  s_req;
   logic [1:0]  s_gnt;
   logic [1:0]  s_gfx_valid;
   logic [23:0] s_gfx_x;
   logic [23:0] s_gfx_y;
   logic [23:0] s_gfx_pixel;
   logic [1:0]  s_gfx_ready;
   logic        m_gfx_valid;
   logic [11:0] m_gfx_x;
   logic [11:0] m_gfx_y;
   logic [11:0] m_gfx_pixel;
   logic        m_gfx_ready;
   logic [11:0] h_visible;
   logic [11:0] v_visible;

   int checks = 0;
   int errors = 0;
   logic [35:0] exp_q[$];

   typedef struct {
      logic [1:0] req;
      logic [1:0] gnt;
   } vec_t;
   vec_t tbl[15];

   gfx_stream_arb #(.NUM_REQ(2), .H_WIDTH(12), .V_WIDTH(12), .PIXEL_WIDTH(12)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_req       (s_req),
      .s_gnt       (s_gnt),
      .s_gfx_valid (s_gfx_valid),
      .s_gfx_x     (s_gfx_x),
      .s_gfx_y     (s_gfx_y),
      .s_gfx_pixel (s_gfx_pixel),
      .s_gfx_ready (s_gfx_ready),
      .m_gfx_valid (m_gfx_valid),
      .m_gfx_x     (m_gfx_x),
      .m_gfx_y     (m_gfx_y),
      .m_gfx_pixel (m_gfx_pixel),
      .m_gfx_ready (m_gfx_ready),
      .h_visible   (h_visible),
      .v_visible   (v_visible)
   );

   // clock / global time limit
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: run still active at %0t, expected finish", $time);
      $fatal(1, "time limit");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit fwd_beat(input logic [11:0] x, input logic [11:0] y);
`ifdef GFX_STREAM_ARB_CLIP_EN
      return (x < 12'd640) && (y < 12'd480);
`else
      return 1'b1;
`endif
   endfunction

   // driver: present one beat on requester i and hold until accepted
   task automatic send_beat(input int i, input logic [11:0] x, input logic [11:0] y,
                            input logic [11:0] p);
      bit fwd;
      bit acc;
      int n;
      fwd = fwd_beat(x, y);
      if (fwd) exp_q.push_back({x, y, p});
      s_gfx_valid[i]        = 1'b1;
      s_gfx_x[i*12 +: 12]     = x;
      s_gfx_y[i*12 +: 12]     = y;
      s_gfx_pixel[i*12 +: 12] = p;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = s_gfx_ready[i];
         @(posedge clk);
         #1;
         n++;
      end
      s_gfx_valid[i] = 1'b0;
      if (!acc) begin
         chk("accept_timeout", 64'(n), 64'(0));
      end else if (fwd) begin
         chk("out_valid_latency", 64'(m_gfx_valid), 64'(1));
         chk("out_x_latency", 64'(m_gfx_x), 64'(x));
      end
   endtask

   // scoreboard monitor: a transfer happens at the edge after valid && ready
   initial begin
      logic [35:0] e;
      forever begin
         @(negedge clk);
         if (!rst && m_gfx_valid && m_gfx_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'({m_gfx_x, m_gfx_y, m_gfx_pixel}), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk("out_beat", 64'({m_gfx_x, m_gfx_y, m_gfx_pixel}), 64'(e));
            end
         end
      end
   end

   initial begin
      tbl[0]  = '{2'b11, 2'b01};
      tbl[1]  = '{2'b11, 2'b01};
      tbl[2]  = '{2'b10, 2'b00};
      tbl[3]  = '{2'b10, 2'b10};
      tbl[4]  = '{2'b10, 2'b10};
      tbl[5]  = '{2'b00, 2'b00};
      tbl[6]  = '{2'b11, 2'b01};
      tbl[7]  = '{2'b01, 2'b01};
      tbl[8]  = '{2'b00, 2'b00};
      tbl[9]  = '{2'b11, 2'b10};
      tbl[10] = '{2'b00, 2'b00};
      tbl[11] = '{2'b10, 2'b10};
      tbl[12] = '{2'b11, 2'b10};
      tbl[13] = '{2'b01, 2'b00};
      tbl[14] = '{2'b01, 2'b01};

      rst = 1'b1;
      s_req = '0;
      s_gfx_valid = '0;
      s_gfx_x = '0;
      s_gfx_y = '0;
      s_gfx_pixel = '0;
      m_gfx_ready = 1'b1;
      h_visible = 12'd640;
      v_visible = 12'd480;
      #12;
      chk("rst_gnt", 64'(s_gnt), 64'(0));
      chk("rst_valid", 64'(m_gfx_valid), 64'(0));
      chk("rst_xypix", 64'({m_gfx_x, m_gfx_y, m_gfx_pixel}), 64'(0));
      chk("rst_ready", 64'(s_gfx_ready), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      tick();

      // grant/round-robin table, no data in flight so ready mirrors the grant
      for (int k = 0; k < 15; k++) begin
         s_req = tbl[k].req;
         tick();
         chk($sformatf("tbl_gnt_%0d", k), 64'(s_gnt), 64'(tbl[k].gnt));
         chk($sformatf("tbl_ready_%0d", k), 64'(s_gfx_ready), 64'(tbl[k].gnt));
      end

      // single owner: four back-to-back beats
      for (int k = 0; k < 4; k++) send_beat(0, 12'(10 + k), 12'd20, 12'hF00);

      // non-owner noise on requester 1
      s_gfx_valid[1] = 1'b1;
      s_gfx_x[23:12] = 12'hABC;
      s_gfx_y[23:12] = 12'h123;
      s_gfx_pixel[23:12] = 12'h777;
      for (int k = 0; k < 4; k++) begin
         send_beat(0, 12'(30 + k), 12'd40, 12'($urandom_range(0, 4095)));
         chk("noise_ready1", 64'(s_gfx_ready[1]), 64'(0));
      end
      s_gfx_valid[1] = 1'b0;

      // backpressure: sink stalls three cycles mid-stream
      fork
         for (int k = 0; k < 8; k++)
            send_beat(0, 12'(100 + k), 12'd50, 12'($urandom_range(0, 4095)));
         begin
            repeat (3) tick();
            m_gfx_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("bp_owner_ready", 64'(s_gfx_ready[0]), 64'(0));
               chk("bp_valid_held", 64'(m_gfx_valid), 64'(1));
               if (exp_q.size() > 0)
                  chk("bp_frozen", 64'({m_gfx_x, m_gfx_y, m_gfx_pixel}), 64'(exp_q[0]));
            end
            tick();
            m_gfx_ready = 1'b1;
         end
      join

      // clip boundary beats
      send_beat(0, 12'd639, 12'd479, 12'h0A1);
      send_beat(0, 12'd640, 12'd0, 12'h0A2);
      send_beat(0, 12'd0, 12'd480, 12'h0A3);
      repeat (3) tick();
      chk("clip_drain", 64'(exp_q.size()), 64'(0));

      // reset mid-transfer: stuck beat must vanish without a clock edge
      m_gfx_ready = 1'b0;
      send_beat(0, 12'd100, 12'd100, 12'h123);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 64'(m_gfx_valid), 64'(0));
      chk("async_rst_gnt", 64'(s_gnt), 64'(0));
      chk("async_rst_x", 64'(m_gfx_x), 64'(0));
      exp_q.delete();
      s_req = '0;
      m_gfx_ready = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_gnt", 64'(s_gnt), 64'(0));
      s_req = 2'b01;
      tick();
      chk("post_rst_regrant", 64'(s_gnt), 64'(1));
      s_req = 2'b00;
      tick();
      chk("post_rst_release", 64'(s_gnt), 64'(0));

      repeat (4) tick();
      chk("final_drain", 64'(exp_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
